decode_stage: RTL

DECODE_STAGE -- requirements
Module: decode_stage

---
 rtl/decode_stage.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/decode_stage.sv
// RV32I decode stage: decodes each accepted instruction and queues the decoded
// fields in a small FIFO whose head drives the outputs.
module decode_stage #(
  parameter int AWIDTH = 32,
  parameter int DWIDTH = 32,
  parameter int DEPTH  = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       insn_valid_i,
  output logic                       insn_ready_o,
  input  logic [DWIDTH-1:0]          insn_i,
  input  logic [AWIDTH-1:0]          pc_i,
  input  logic                       flush_i,
  output logic                       valid_o,
  input  logic                       ready_i,
  output logic [DWIDTH-1:0]          insn_o,
  output logic [AWIDTH-1:0]          pc_o,
  output logic [6:0]                 opcode_o,
  output logic [6:0]                 funct7_o,
  output logic [4:0]                 rd_o,
  output logic [4:0]                 rs1_o,
  output logic [4:0]                 rs2_o,
  output logic [4:0]                 shamt_o,
  output logic [2:0]                 funct3_o,
  output logic [DWIDTH-1:0]          imm_o,
  output logic                       illegal_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  typedef struct packed {
    logic [DWIDTH-1:0] insn;
    logic [AWIDTH-1:0] pc;
    logic [6:0]        opcode;
    logic [6:0]        funct7;
    logic [4:0]        rd;
    logic [4:0]        rs1;
    logic [4:0]        rs2;
    logic [4:0]        shamt;
    logic [2:0]        funct3;
    logic [DWIDTH-1:0] imm;
    logic              illegal;
  } entry_t;

  entry_t          dec;
  entry_t          head_entry;
  entry_t          mem [DEPTH];
  logic [PW-1:0]   head_reg;
  logic [PW-1:0]   tail_reg;
  logic [CW-1:0]   count_reg;
  logic [CW-1:0]   count_next;
  logic            push;
  logic            pop;
  logic            is_shift;

  assign insn_ready_o = (count_reg < CW'(DEPTH));
  assign valid_o      = (count_reg != '0);
  assign count_o      = count_reg;
  assign push         = insn_valid_i && insn_ready_o && !flush_i;
  assign pop          = valid_o && ready_i && !flush_i;
  assign is_shift     = (insn_i[6:0] == OPC_OP_IMM) &&
                        ((insn_i[14:12] == 3'b001) || (insn_i[14:12] == 3'b101));

  // Decode happens on the way in, so the head entry is ready the cycle after a push.
  always_comb begin
    dec        = '0;
    dec.insn   = insn_i;
    dec.pc     = pc_i;
    dec.opcode = insn_i[6:0];
    dec.rd     = insn_i[11:7];
    dec.funct3 = insn_i[14:12];
    dec.rs1    = insn_i[19:15];
    dec.rs2    = insn_i[24:20];
    case (insn_i[6:0])
      OPC_OP: begin
        dec.funct7 = insn_i[31:25];
      end
      OPC_OP_IMM: begin
        dec.rs2 = '0;
        dec.imm = {{20{insn_i[31]}}, insn_i[31:20]};
        if (is_shift) begin
          dec.funct7 = insn_i[31:25];
          dec.shamt  = insn_i[24:20];
        end
      end
      OPC_LOAD, OPC_JALR: begin
        dec.rs2 = '0;
        dec.imm = {{20{insn_i[31]}}, insn_i[31:20]};
      end
      OPC_STORE: begin
        dec.rd  = '0;
        dec.imm = {{20{insn_i[31]}}, insn_i[31:25], insn_i[11:7]};
      end
      OPC_BRANCH: begin
        dec.rd  = '0;
        dec.imm = {{19{insn_i[31]}}, insn_i[31], insn_i[7], insn_i[30:25],
                   insn_i[11:8], 1'b0};
      end
      OPC_LUI, OPC_AUIPC: begin
        dec.rs1    = '0;
        dec.funct3 = '0;
        dec.rs2    = '0;
        dec.imm    = {insn_i[31:12], 12'h000};
      end
      OPC_JAL: begin
        dec.rs1    = '0;
        dec.funct3 = '0;
        dec.rs2    = '0;
        dec.imm    = {{11{insn_i[31]}}, insn_i[31], insn_i[19:12], insn_i[20],
                      insn_i[30:21], 1'b0};
      end
      default: begin
        dec.opcode  = '0;
        dec.rd      = '0;
        dec.funct3  = '0;
        dec.rs1     = '0;
        dec.rs2     = '0;
        dec.illegal = 1'b1;
      end
    endcase
  end

  always_comb begin
    count_next = count_reg;
    case ({push, pop})
      2'b10:   count_next = count_reg + CW'(1);
      2'b01:   count_next = count_reg - CW'(1);
      default: count_next = count_reg;
    endcase
  end

  // Payload storage carries no reset; visibility is governed by count_reg alone.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[tail_reg] <= dec;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
    end else if (flush_i) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
    end else begin
      if (push) tail_reg <= tail_reg + PW'(1);
      if (pop)  head_reg <= head_reg + PW'(1);
      count_reg <= count_next;
    end
  end

  // Gating on valid_o forces every data output to zero while empty or in reset.
  assign head_entry = valid_o ? mem[head_reg] : '0;

  assign insn_o    = head_entry.insn;
  assign pc_o      = head_entry.pc;
  assign opcode_o  = head_entry.opcode;
  assign funct7_o  = head_entry.funct7;
  assign rd_o      = head_entry.rd;
  assign rs1_o     = head_entry.rs1;
  assign rs2_o     = head_entry.rs2;
  assign shamt_o   = head_entry.shamt;
  assign funct3_o  = head_entry.funct3;
  assign imm_o     = head_entry.imm;
  assign illegal_o = head_entry.illegal;

endmodule
